// File: rtl/misc_pipe_pkg.sv
// Shared types for the five-stage core's hazard logic: forward-select codes,
// the per-stage destination shadow slot and the hazard controller state.
package misc_pipe_pkg;

    localparam int SLOT_RD_W = 16;

    localparam logic [1:0] FWD_MEM = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_RF  = 2'b10;
    localparam logic       FWD3_WB = 1'b0;
    localparam logic       FWD3_RF = 1'b1;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } pipeSlot_t;

    localparam pipeSlot_t SLOT_EMPTY = '0;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FREEZE
    } hazState_t;

endpackage

// File: rtl/haz_match.sv
// Combinational source/slot comparator: flags a live producer of a source register.
// Zero latency, no flow control; register 0 never matches.
module haz_match
    import misc_pipe_pkg::*;
#(
    parameter int REG_W = SLOT_RD_W
)
(
    input  logic             slotValid,
    input  logic [REG_W-1:0] slotRd,
    input  logic             slotWrite,
    input  logic [REG_W-1:0] src,
    input  logic             srcUse,
    output logic             hit
);

    assign hit = slotValid && slotWrite && srcUse && (slotRd == src) && (src != '0);

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller: registered EX forward selects, combinational stall/bubble/flush/freeze.
// Forwarding network is present only with HAZ_FWD_EN defined; otherwise every RAW dependence stalls.
module hazard_controller
    import misc_pipe_pkg::*;
#(
    parameter int REG_W = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rs3,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_use3,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             freeze,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic             fwd3_sel
);

    hazState_t state, nextState, heldState;
    pipeSlot_t exSlot, memSlot, decSlot;

    logic [SLOT_RD_W-1:0] srcIdx [3];
    logic [2:0]           srcUse;
    logic [2:0]           exHit;
    logic [2:0]           memHit;
    logic                 hazard;

    assign srcIdx[0] = SLOT_RD_W'(id_rs1);
    assign srcIdx[1] = SLOT_RD_W'(id_rs2);
    assign srcIdx[2] = SLOT_RD_W'(id_rs3);
    assign srcUse    = {id_use3, id_use2, id_use1} & {3{id_valid}};

    assign decSlot.valid    = id_valid;
    assign decSlot.rd       = SLOT_RD_W'(id_rd);
    assign decSlot.regwrite = id_regwrite;
    assign decSlot.memread  = id_memread;

    for (genvar g = 0; g < 3; g++) begin : gMatch
        haz_match #(.REG_W(SLOT_RD_W)) uExMatch (
            .slotValid (exSlot.valid),
            .slotRd    (exSlot.rd),
            .slotWrite (exSlot.regwrite),
            .src       (srcIdx[g]),
            .srcUse    (srcUse[g]),
            .hit       (exHit[g])
        );
        haz_match #(.REG_W(SLOT_RD_W)) uMemMatch (
            .slotValid (memSlot.valid),
            .slotRd    (memSlot.rd),
            .slotWrite (memSlot.regwrite),
            .src       (srcIdx[g]),
            .srcUse    (srcUse[g]),
            .hit       (memHit[g])
        );
    end

`ifdef HAZ_FWD_EN
    // Store data can only be forwarded from WB, so any EX producer of rs3 costs a cycle.
    assign hazard = ((exHit[0] || exHit[1]) && exSlot.memread) || exHit[2];
`else
    assign hazard = |(exHit | memHit);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            heldState <= RUN;
        end else begin
            state <= nextState;
            if (mem_busy && state != FREEZE) begin
                heldState <= state;
            end
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            RUN:     if (hazard)  nextState = STALL;
            STALL:   if (!hazard) nextState = RUN;
            FREEZE:  nextState = heldState;
            default: nextState = RUN;
        endcase
        if (ex_redirect) nextState = RUN;
        if (mem_busy)    nextState = FREEZE;
    end

    // Gated by reset so every control drops the instant reset asserts.
    always_comb begin
        stall_pc    = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze      = 1'b0;
        if (reset) begin
            if (mem_busy) begin
                freeze = 1'b1;
            end else if (ex_redirect) begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end else if (hazard) begin
                stall_pc    = 1'b1;
                bubble_idex = 1'b1;
            end
        end
    end

    // The WB stage is not shadowed: the write-through register file already returns its value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exSlot  <= SLOT_EMPTY;
            memSlot <= SLOT_EMPTY;
        end else if (!mem_busy) begin
            memSlot <= exSlot;
            exSlot  <= (bubble_idex || !id_valid) ? SLOT_EMPTY : decSlot;
        end
    end

`ifdef HAZ_FWD_EN
    logic [1:0] sel1Next, sel2Next;
    logic       sel3Next;

    always_comb begin
        sel1Next = FWD_RF;
        sel2Next = FWD_RF;
        if (exHit[0] && !exSlot.memread) sel1Next = FWD_MEM;
        else if (memHit[0])              sel1Next = FWD_WB;
        if (exHit[1] && !exSlot.memread) sel2Next = FWD_MEM;
        else if (memHit[1])              sel2Next = FWD_WB;
        sel3Next = memHit[2] ? FWD3_WB : FWD3_RF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd1_sel <= FWD_RF;
            fwd2_sel <= FWD_RF;
            fwd3_sel <= FWD3_RF;
        end else if (!mem_busy && !bubble_idex) begin
            fwd1_sel <= sel1Next;
            fwd2_sel <= sel2Next;
            fwd3_sel <= sel3Next;
        end
    end
`else
    assign fwd1_sel = FWD_RF;
    assign fwd2_sel = FWD_RF;
    assign fwd3_sel = FWD3_RF;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: scenario table, hand-written corner sequences and a random run
// against a pipeline-occupancy reference model.
module tb_hazard_controller;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit v;
        int rs1, rs2, rs3;
        bit u1, u2, u3;
        int rd;
        bit wr, ld;
    } inst_t;

    typedef struct {
        inst_t      p;
        bit         hasG;
        inst_t      g;
        inst_t      c;
        int         stF, stN;
        logic [1:0] f1, f2;
        logic       f3;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        idValid = 1'b0;
    logic [15:0] idRs1 = '0, idRs2 = '0, idRs3 = '0, idRd = '0;
    logic        idUse1 = 1'b0, idUse2 = 1'b0, idUse3 = 1'b0;
    logic        idRegwrite = 1'b0, idMemread = 1'b0;
    logic        exRedirect = 1'b0, memBusy = 1'b0;
    logic        stallPc, bubbleIdex, flushIfid, freezeO;
    logic [1:0]  fwd1, fwd2;
    logic        fwd3;

    int checks = 0;
    int errors = 0;

    inst_t mdl [2];
    vec_t  tbl [12];

    always #5 clk = ~clk;

    hazard_controller #(.REG_W(16)) dut (
        .clk         (clk),
        .reset       (resetN),
        .id_valid    (idValid),
        .id_rs1      (idRs1),
        .id_rs2      (idRs2),
        .id_rs3      (idRs3),
        .id_use1     (idUse1),
        .id_use2     (idUse2),
        .id_use3     (idUse3),
        .id_rd       (idRd),
        .id_regwrite (idRegwrite),
        .id_memread  (idMemread),
        .ex_redirect (exRedirect),
        .mem_busy    (memBusy),
        .stall_pc    (stallPc),
        .bubble_idex (bubbleIdex),
        .flush_ifid  (flushIfid),
        .freeze      (freezeO),
        .fwd1_sel    (fwd1),
        .fwd2_sel    (fwd2),
        .fwd3_sel    (fwd3)
    );

    function automatic inst_t mk(int rs1, bit u1, int rs2, bit u2, int rs3, bit u3,
                                 int rd, bit wr, bit ld);
        inst_t i;
        i.v = 1'b1; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
        i.rs3 = rs3; i.u3 = u3; i.rd = rd; i.wr = wr; i.ld = ld;
        return i;
    endfunction

    function automatic inst_t nop();
        inst_t i;
        i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        i.v = 1'b0;
        return i;
    endfunction

    function automatic vec_t mkVec(inst_t p, bit hasG, inst_t g, inst_t c, int stF, int stN,
                                   logic [1:0] f1, logic [1:0] f2, logic f3);
        vec_t e;
        e.p = p; e.hasG = hasG; e.g = g; e.c = c; e.stF = stF; e.stN = stN;
        e.f1 = f1; e.f2 = f2; e.f3 = f3;
        return e;
    endfunction

    task automatic drive(input inst_t i, input bit redir, input bit busy);
        idValid    = i.v;
        idRs1      = 16'(i.rs1);
        idRs2      = 16'(i.rs2);
        idRs3      = 16'(i.rs3);
        idUse1     = i.u1;
        idUse2     = i.u2;
        idUse3     = i.u3;
        idRd       = 16'(i.rd);
        idRegwrite = i.wr;
        idMemread  = i.ld;
        exRedirect = redir;
        memBusy    = busy;
    endtask

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic doReset();
        resetN = 1'b0;
        drive(nop(), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    // Holds an instruction in ID through the expected number of stall cycles, then lets it advance.
    task automatic issue(input inst_t i, input int nStall, input string tag);
        for (int k = 0; k < nStall; k++) begin
            drive(i, 1'b0, 1'b0);
            #1;
            chk({tag, "_stall"}, stallPc, 1);
            chk({tag, "_bubble"}, bubbleIdex, 1);
            @(posedge clk);
            #1;
        end
        drive(i, 1'b0, 1'b0);
        #1;
        chk({tag, "_go"}, stallPc, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int youngest(inst_t id, int src, bit u);
        if (!id.v || !u || src == 0) return -1;
        for (int k = 0; k < 2; k++) begin
            if (mdl[k].v && mdl[k].wr && mdl[k].rd == src) return k;
        end
        return -1;
    endfunction

    function automatic bit mHaz(inst_t id);
        int p1, p2, p3;
        p1 = youngest(id, id.rs1, id.u1);
        p2 = youngest(id, id.rs2, id.u2);
        p3 = youngest(id, id.rs3, id.u3);
        if (FWD) return ((p1 == 0 || p2 == 0) && mdl[0].ld) || p3 == 0;
        return p1 >= 0 || p2 >= 0 || p3 >= 0;
    endfunction

    function automatic logic [1:0] mSel(int p);
        if (!FWD) return 2'd2;
        return (p == 0) ? 2'd0 : (p == 1) ? 2'd1 : 2'd2;
    endfunction

    function automatic inst_t rndInst();
        inst_t i;
        i = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        i.v = $urandom_range(0, 7) != 0;
        return i;
    endfunction

    initial begin
        inst_t addR3, lwR2, lwDep, useR2, idInst;
        logic [1:0] preF1;
        logic [1:0] mf1, mf2;
        logic       mf3;
        bit         holdRedir;

        addR3 = mk(0, 0, 0, 0, 0, 0, 3, 1, 0);
        lwR2  = mk(0, 0, 0, 0, 0, 0, 2, 1, 1);
        lwDep = mk(3, 1, 0, 0, 0, 0, 2, 1, 1);
        useR2 = mk(2, 1, 2, 1, 0, 0, 6, 1, 0);

        tbl[0]  = mkVec(addR3, 0, nop(), mk(3, 1, 5, 1, 0, 0, 4, 1, 0), 0, 2, 2'd0, 2'd2, 1'b1);
        tbl[1]  = mkVec(lwR2, 0, nop(), useR2, 1, 2, 2'd1, 2'd1, 1'b1);
        tbl[2]  = mkVec(mk(0, 0, 0, 0, 0, 0, 7, 1, 0), 0, nop(), mk(1, 1, 0, 0, 7, 1, 0, 0, 0),
                        1, 2, 2'd2, 2'd2, 1'b0);
        tbl[3]  = mkVec(addR3, 1, nop(), mk(3, 1, 0, 0, 0, 0, 4, 1, 0), 0, 1, 2'd1, 2'd2, 1'b1);
        tbl[4]  = mkVec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 0, nop(), mk(0, 1, 0, 1, 0, 1, 4, 1, 0),
                        0, 0, 2'd2, 2'd2, 1'b1);
        tbl[5]  = mkVec(lwR2, 1, nop(), mk(1, 1, 0, 0, 2, 1, 0, 0, 0), 0, 1, 2'd2, 2'd2, 1'b0);
        tbl[6]  = mkVec(mk(0, 0, 0, 0, 0, 0, 5, 0, 0), 0, nop(), mk(5, 1, 0, 0, 0, 0, 4, 1, 0),
                        0, 0, 2'd2, 2'd2, 1'b1);
        tbl[7]  = mkVec(mk(0, 0, 0, 0, 0, 0, 4, 1, 0), 0, nop(), mk(4, 0, 4, 0, 0, 0, 6, 1, 0),
                        0, 0, 2'd2, 2'd2, 1'b1);
        tbl[8]  = mkVec(addR3, 1, addR3, mk(3, 1, 0, 0, 0, 0, 4, 1, 0), 0, 2, 2'd0, 2'd2, 1'b1);
        tbl[9]  = mkVec(lwR2, 1, mk(0, 0, 0, 0, 0, 0, 2, 1, 0), useR2, 0, 2, 2'd0, 2'd0, 1'b1);
        tbl[10] = mkVec(addR3, 1, mk(0, 0, 0, 0, 0, 0, 3, 1, 1), mk(3, 1, 0, 0, 0, 0, 4, 1, 0),
                        1, 2, 2'd1, 2'd2, 1'b1);
        tbl[11] = mkVec(lwR2, 0, nop(), mk(9, 1, 2, 1, 0, 0, 4, 1, 0), 1, 2, 2'd2, 2'd1, 1'b1);

        // Reset state.
        doReset();
        drive(nop(), 1'b0, 1'b0);
        #1;
        chk("rst_stall", stallPc, 0);
        chk("rst_bubble", bubbleIdex, 0);
        chk("rst_flush", flushIfid, 0);
        chk("rst_freeze", freezeO, 0);
        chk("rst_fwd1", fwd1, 2);
        chk("rst_fwd2", fwd2, 2);
        chk("rst_fwd3", fwd3, 1);
        @(posedge clk);
        #1;

        foreach (tbl[n]) begin
            doReset();
            issue(tbl[n].p, 0, $sformatf("v%0d_p", n));
            if (tbl[n].hasG) issue(tbl[n].g, 0, $sformatf("v%0d_g", n));
            issue(tbl[n].c, FWD ? tbl[n].stF : tbl[n].stN, $sformatf("v%0d_c", n));
            chk($sformatf("v%0d_fwd1", n), fwd1, FWD ? tbl[n].f1 : 2'd2);
            chk($sformatf("v%0d_fwd2", n), fwd2, FWD ? tbl[n].f2 : 2'd2);
            chk($sformatf("v%0d_fwd3", n), fwd3, FWD ? tbl[n].f3 : 1'b1);
        end

        preF1 = FWD ? 2'd0 : 2'd2;

        // Redirect in the same cycle as a load-use hazard.
        doReset();
        issue(addR3, 0, "rd_p");
        issue(lwDep, FWD ? 0 : 2, "rd_lw");
        chk("rd_pre_fwd1", fwd1, preF1);
        drive(useR2, 1'b1, 1'b0);
        #1;
        chk("rd_flush", flushIfid, 1);
        chk("rd_bubble", bubbleIdex, 1);
        chk("rd_stall", stallPc, 0);
        @(posedge clk);
        #1;
        chk("rd_hold_fwd1", fwd1, preF1);
        drive(nop(), 1'b0, 1'b0);
        #1;
        chk("rd_after_stall", stallPc, 0);
        chk("rd_after_bubble", bubbleIdex, 0);
        @(posedge clk);
        #1;

        // Memory freeze during a load-use stall.
        doReset();
        issue(addR3, 0, "fz_p");
        issue(lwDep, FWD ? 0 : 2, "fz_lw");
        for (int k = 0; k < 3; k++) begin
            drive(useR2, 1'b0, 1'b1);
            #1;
            chk("fz_freeze", freezeO, 1);
            chk("fz_stall", stallPc, 0);
            @(posedge clk);
            #1;
            chk("fz_hold_fwd1", fwd1, preF1);
        end
        issue(useR2, FWD ? 1 : 2, "fz_c");
        chk("fz_fwd1", fwd1, FWD ? 2'd1 : 2'd2);
        chk("fz_fwd2", fwd2, FWD ? 2'd1 : 2'd2);

        // Reset asserted in the middle of a stall.
        doReset();
        issue(addR3, 0, "rs_p");
        issue(lwDep, FWD ? 0 : 2, "rs_lw");
        drive(useR2, 1'b0, 1'b0);
        #1;
        chk("rs_pre_stall", stallPc, 1);
        memBusy = 1'b1;
        resetN  = 1'b0;
        #1;
        chk("rs_stall", stallPc, 0);
        chk("rs_bubble", bubbleIdex, 0);
        chk("rs_flush", flushIfid, 0);
        chk("rs_freeze", freezeO, 0);
        chk("rs_fwd1", fwd1, 2);
        chk("rs_fwd2", fwd2, 2);
        chk("rs_fwd3", fwd3, 1);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        drive(useR2, 1'b0, 1'b0);
        #1;
        chk("rs_after_stall", stallPc, 0);
        @(posedge clk);
        #1;

        // Random run against the occupancy model.
        doReset();
        mdl[0] = nop();
        mdl[1] = nop();
        mf1 = 2'd2; mf2 = 2'd2; mf3 = 1'b1;
        holdRedir = 1'b0;
        idInst = rndInst();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit busy, redir, haz, eStall, eBubble, eFlush;
            busy  = $urandom_range(0, 6) == 0;
            redir = holdRedir || ($urandom_range(0, 9) == 0);
            drive(idInst, redir, busy);
            #1;
            haz     = mHaz(idInst);
            eFlush  = !busy && redir;
            eStall  = !busy && !redir && haz;
            eBubble = !busy && (redir || haz);
            chk("rnd_freeze", freezeO, busy);
            chk("rnd_flush", flushIfid, eFlush);
            chk("rnd_stall", stallPc, eStall);
            chk("rnd_bubble", bubbleIdex, eBubble);
            @(posedge clk);
            #1;
            if (!busy) begin
                if (!eBubble && FWD) begin
                    mf1 = mSel(youngest(idInst, idInst.rs1, idInst.u1));
                    mf2 = mSel(youngest(idInst, idInst.rs2, idInst.u2));
                    mf3 = (youngest(idInst, idInst.rs3, idInst.u3) == 1) ? 1'b0 : 1'b1;
                end
                mdl[1] = mdl[0];
                mdl[0] = (eBubble || !idInst.v) ? nop() : idInst;
            end
            chk("rnd_fwd1", fwd1, mf1);
            chk("rnd_fwd2", fwd2, mf2);
            chk("rnd_fwd3", fwd3, mf3);
            if (busy) begin
                holdRedir = redir;
            end else begin
                holdRedir = 1'b0;
                if (redir)        idInst = nop();
                else if (!eStall) idInst = rndInst();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
